// File: rtl/timer_ctrl.sv
// ============================================================================
// timer_ctrl
// ----------------------------------------------------------------------------
// Programmable interval timer controller. A free-running modulo-PRE_M
// prescaler produces ticks while the timer runs. A period counter counts
// those ticks up to the latched period. An IDLE/RUN/PAUSE state machine
// sequences both counters and supports one-shot and periodic operation.
//
// Parameters:
//   PRE_M  clock cycles per tick (>= 1)
//   CW     width of the period input and of the tick counter
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   start from IDLE, or resume from PAUSE
//   stop    abort and return to IDLE (highest priority)
//   pause   freeze while in RUN (lowest priority)
//   mode    0 = one-shot, 1 = periodic; latched when a start is accepted
//   period  ticks per interval; latched when a start is accepted
//   busy    timer is not idle
//   paused  timer is frozen
//   tick    prescaler carry; high only in RUN
//   cnt     current tick count within the interval
//   done    one-cycle pulse after an interval completes
//   err     one-cycle pulse after a start with period == 0
// ============================================================================
module timer_ctrl #(
    parameter int PRE_M = 100,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          mode,
    input  logic [CW-1:0] period,
    output logic          busy,
    output logic          paused,
    output logic          tick,
    output logic [CW-1:0] cnt,
    output logic          done,
    output logic          err
);

    // A modulus of 1 still needs a 1-bit register. That bit simply stays at 0.
    localparam int            PW       = (PRE_M > 1) ? $clog2(PRE_M) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_M - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] per_q, per_d;
    logic          mode_q, mode_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] last_cnt;
    logic          wrap;

    // per_q is never 0 while running, so the subtraction cannot underflow
    // in any state where it is used.
    assign last_cnt = per_q - CW'(1);
    assign tick     = (state_q == RUN) && (pre_q == PRE_LAST);
    assign wrap     = tick && (cnt_q == last_cnt);

    // Next-state and datapath logic. Requests are prioritised stop > start > pause.
    // The cycle in which pause is taken is still a RUN cycle, so the prescaler
    // and any coincident tick are processed before the freeze.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    if (period == '0) begin
                        err_d = 1'b1;
                    end else begin
                        per_d   = period;
                        mode_d  = mode;
                        pre_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end else begin
                    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
                    if (wrap) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else if (tick) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // A completed one-shot interval takes precedence over pause.
                    if (wrap && !mode_q) begin
                        state_d = IDLE;
                    end else if (pause && !start) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign paused = (state_q == PAUSE);
    assign cnt    = cnt_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// tb_timer_ctrl
// ----------------------------------------------------------------------------
// Drives two timer_ctrl instances (PRE_M=4 and PRE_M=1, both CW=8) from the
// same request inputs. Each one is compared every cycle against a reference
// model. The model tracks the number of RUN cycles elapsed in the current
// interval. It derives the tick, the count and the completion point from that
// number with plain division and modulo.
// ============================================================================
module tb_timer_ctrl;

    localparam int CW      = 8;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_PAUSE = 2;

    logic          clk;
    logic          rst_n;
    logic          startReq;
    logic          stopReq;
    logic          pauseReq;
    logic          modeSel;
    logic [CW-1:0] periodVal;

    logic          busy4, paused4, tick4, done4, err4;
    logic [CW-1:0] cnt4;
    logic          busy1, paused1, tick1, done1, err1;
    logic [CW-1:0] cnt1;

    int total;
    int bad;
    int edgeNum;

    int preM   [2];
    int mPhase [2];
    int mRun   [2];
    int mPer   [2];
    bit mMode  [2];
    bit mDone  [2];
    bit mErr   [2];

    timer_ctrl #(.PRE_M(4), .CW(CW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(startReq), .stop(stopReq), .pause(pauseReq),
        .mode(modeSel), .period(periodVal), .busy(busy4), .paused(paused4), .tick(tick4),
        .cnt(cnt4), .done(done4), .err(err4)
    );

    timer_ctrl #(.PRE_M(1), .CW(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(startReq), .stop(stopReq), .pause(pauseReq),
        .mode(modeSel), .period(periodVal), .busy(busy1), .paused(paused1), .tick(tick1),
        .cnt(cnt1), .done(done1), .err(err1)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. Every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mPhase[k] = P_IDLE;
            mRun[k]   = 0;
            mPer[k]   = 0;
            mMode[k]  = 1'b0;
            mDone[k]  = 1'b0;
            mErr[k]   = 1'b0;
        end
    endtask

    // Advance model k by one clock edge using the requests present at that edge.
    task automatic modelStep(input int k);
        int pm;
        pm       = preM[k];
        mDone[k] = 1'b0;
        mErr[k]  = 1'b0;
        case (mPhase[k])
            P_IDLE: begin
                if (!stopReq && startReq) begin
                    if (periodVal == 0) begin
                        mErr[k] = 1'b1;
                    end else begin
                        mPer[k]   = int'(periodVal);
                        mMode[k]  = modeSel;
                        mRun[k]   = 0;
                        mPhase[k] = P_RUN;
                    end
                end
            end
            P_RUN: begin
                if (stopReq) begin
                    mPhase[k] = P_IDLE;
                    mRun[k]   = 0;
                end else if (mRun[k] + 1 == pm * mPer[k]) begin
                    mDone[k] = 1'b1;
                    mRun[k]  = 0;
                    if (!mMode[k]) mPhase[k] = P_IDLE;
                    else if (pauseReq && !startReq) mPhase[k] = P_PAUSE;
                end else begin
                    mRun[k] = mRun[k] + 1;
                    if (pauseReq && !startReq) mPhase[k] = P_PAUSE;
                end
            end
            default: begin
                if (stopReq) begin
                    mPhase[k] = P_IDLE;
                    mRun[k]   = 0;
                end else if (startReq) begin
                    mPhase[k] = P_RUN;
                end
            end
        endcase
    endtask

    // Compare every output of instance k against its model.
    task automatic checkDut(input int k);
        int pm;
        bit expTick;
        pm      = preM[k];
        expTick = (mPhase[k] == P_RUN) && ((mRun[k] % pm) == pm - 1);
        if (k == 0) begin
            checkOutput("busy4",   32'(busy4),   32'(mPhase[0] != P_IDLE));
            checkOutput("paused4", 32'(paused4), 32'(mPhase[0] == P_PAUSE));
            checkOutput("tick4",   32'(tick4),   32'(expTick));
            checkOutput("cnt4",    32'(cnt4),    32'(mRun[0] / pm));
            checkOutput("done4",   32'(done4),   32'(mDone[0]));
            checkOutput("err4",    32'(err4),    32'(mErr[0]));
        end else begin
            checkOutput("busy1",   32'(busy1),   32'(mPhase[1] != P_IDLE));
            checkOutput("paused1", 32'(paused1), 32'(mPhase[1] == P_PAUSE));
            checkOutput("tick1",   32'(tick1),   32'(expTick));
            checkOutput("cnt1",    32'(cnt1),    32'(mRun[1] / pm));
            checkOutput("done1",   32'(done1),   32'(mDone[1]));
            checkOutput("err1",    32'(err1),    32'(mErr[1]));
        end
    endtask

    // One clock cycle: drive requests (called at a falling edge), let the
    // rising edge happen, step the models, then check at the next falling edge.
    task automatic applyStimulus(input bit st, input bit sp, input bit pa, input bit md, input int per);
        startReq  = st;
        stopReq   = sp;
        pauseReq  = pa;
        modeSel   = md;
        periodVal = CW'(per);
        @(posedge clk);
        edgeNum++;
        modelStep(0);
        modelStep(1);
        @(negedge clk);
        checkDut(0);
        checkDut(1);
    endtask

    // Pull reset low between edges and check that the outputs clear
    // before any further clock edge occurs.
    task automatic applyReset();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkDut(0);
        checkDut(1);
        @(negedge clk);
        rst_n = 1'b1;
        checkDut(0);
        checkDut(1);
    endtask

    initial begin
        int startEdge;
        int doneEdge;
        int doneCount;
        total     = 0;
        bad       = 0;
        edgeNum   = 0;
        preM[0]   = 4;
        preM[1]   = 1;
        rst_n     = 1'b0;
        startReq  = 1'b0;
        stopReq   = 1'b0;
        pauseReq  = 1'b0;
        modeSel   = 1'b0;
        periodVal = '0;
        modelReset();
        #2;
        checkDut(0);
        checkDut(1);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot, period 3: the completion pulse appears after edge E12.
        applyStimulus(1, 0, 0, 0, 3);
        startEdge = edgeNum;
        doneEdge  = -1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 0, 0, 1, 7);
            if (done4 && doneEdge < 0) doneEdge = edgeNum;
        end
        checkOutput("oneshot_done_edge", 32'(doneEdge - startEdge), 32'd12);

        // Periodic, period 3: three completions in 36 cycles.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 3);
        doneCount = 0;
        for (int i = 0; i < 36; i++) begin
            applyStimulus(0, 0, 0, 0, 5);
            if (done4) doneCount++;
        end
        checkOutput("periodic_done_count", 32'(doneCount), 32'd3);

        // Pause for 5 cycles after E5, then resume.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0);

        // Zero period raises err. A following start with period 2 runs normally.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 2);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);

        // stop and start together in RUN, then reset mid-run.
        applyStimulus(1, 0, 0, 1, 4);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 4);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        applyReset();

        // PRE_M=1, period 1 periodic: done every cycle, even with a new period input.
        applyStimulus(1, 0, 0, 1, 1);
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, (i < 3) ? 1 : 5);
            if (done1) doneCount++;
        end
        checkOutput("prem1_done_count", 32'(doneCount), 32'd8);
        applyStimulus(0, 1, 0, 0, 0);

        // Randomised traffic with an occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                              $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 6)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
